// File: rtl/npu_pool_quant_if.sv
`default_nettype none
// ============================================================================
// Module   : npu_pool_quant_if
// Brief    : Row-stream interface for the pooling/requantization output stage.
//            Carries the accumulator-row input channel and the pooled-row
//            output channel, each with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface npu_pool_quant_if #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int BG    = 6,
  parameter int ACC_W = 2*N+BG+$clog2(25*16)
);
  localparam int c_RW = $clog2(W);

  // Accumulator row channel (upstream -> stage)
  logic                   in_valid;
  logic                   in_ready;
  logic [W*ACC_W-1:0]     in_data;
  logic                   in_last;

  // Pooled row channel (stage -> downstream)
  logic                   out_valid;
  logic                   out_ready;
  logic [(W/2)*N-1:0]     out_data;
  logic                   out_last;
  logic [c_RW-1:0]        out_row;

  // Source/sink side: drives input rows and the downstream ready
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_row
  );

  // Pooling stage side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_row
  );
endinterface
`default_nettype wire

// File: rtl/npu_pool_quant.sv
`default_nettype none
// ============================================================================
// Module   : npu_pool_quant
// Brief    : Convolution-array output stage. Per accumulator row: ReLU,
//            arithmetic right-shift requantization, N-bit unsigned
//            saturation, then 2x2 stride-2 max-pooling over row pairs.
//            Emits W/2 N-bit activations per pooled row.
// Revision : 1.0 - initial release
// ============================================================================
module npu_pool_quant #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int BG    = 6,
  parameter int ACC_W = 2*N+BG+$clog2(25*16),
  parameter int SH_W  = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [SH_W-1:0] shift,
  npu_pool_quant_if.slave      bus
);

  localparam int c_HW   = W/2;
  localparam int c_RW   = $clog2(W);
  localparam int c_ROWS = W/2;
  localparam logic [ACC_W-1:0] c_QMAX = ACC_W'((1 << N) - 1);

  typedef enum logic [0:0] {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    first_row_q;
  logic [SH_W-1:0]         shift_q;
  logic [c_HW*N-1:0]       row_buf_q;
  logic                    out_valid_q;
  logic [c_HW*N-1:0]       out_data_q;
  logic                    out_last_q;
  logic [c_RW-1:0]         out_row_q;

  logic [SH_W-1:0]         w_shift;
  logic [W*N-1:0]          w_q;
  logic [c_HW*N-1:0]       w_h;
  logic [c_HW*N-1:0]       w_v;
  logic                    w_out_free;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_load;
  logic [c_HW*N-1:0]       w_out_data_d;
  logic                    w_out_last_d;
  logic [c_RW-1:0]         w_out_row_inc;

  // ReLU, truncating right shift, then clamp into the unsigned N-bit range.
  function automatic logic [N-1:0] quant(input logic signed [ACC_W-1:0] x,
                                         input logic [SH_W-1:0]         sh);
    logic [ACC_W-1:0] y;
    logic [N-1:0]     q;
    y = '0;
    q = '0;
    if (x > 0) begin
      y = $unsigned(x) >> sh;
      q = (y > c_QMAX) ? c_QMAX[N-1:0] : y[N-1:0];
    end
    return q;
  endfunction

  // The tile's first beat uses the live shift input; later beats use the latched copy.
  assign w_shift = first_row_q ? shift : shift_q;

  // Quantize every element of the incoming row.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < W; i++) begin
      w_q[i*N +: N] = quant(bus.in_data[i*ACC_W +: ACC_W], w_shift);
    end
  end

  // Horizontal pool of adjacent pairs, then vertical pool against the buffered top row.
  always_comb begin
    w_h = '0;
    w_v = '0;
    for (int j = 0; j < c_HW; j++) begin
      w_h[j*N +: N] = (w_q[(2*j)*N +: N] > w_q[(2*j+1)*N +: N]) ?
                      w_q[(2*j)*N +: N] : w_q[(2*j+1)*N +: N];
      w_v[j*N +: N] = (row_buf_q[j*N +: N] > w_h[j*N +: N]) ?
                      row_buf_q[j*N +: N] : w_h[j*N +: N];
    end
  end

  // A top row can always be buffered; any row that produces output needs a free output slot.
  always_comb begin
    w_out_free = !out_valid_q || bus.out_ready;
    if (state_q == S_ODD) begin
      w_in_ready = w_out_free;
    end else begin
      w_in_ready = !bus.in_last || w_out_free;
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_xfer   = out_valid_q && bus.out_ready;
  assign w_load   = w_accept && ((state_q == S_ODD) || bus.in_last);

  // Select what a producing beat loads: a vertical pair, or a lone closing top row.
  always_comb begin
    w_out_data_d = out_data_q;
    w_out_last_d = out_last_q;
    if (state_q == S_ODD) begin
      w_out_data_d = w_v;
      w_out_last_d = bus.in_last;
    end else begin
      w_out_data_d = w_h;
      w_out_last_d = 1'b1;
    end
  end

  // Output row index wraps at tile end and also every W/2 pooled rows.
  assign w_out_row_inc = (out_last_q || (out_row_q == c_RW'(c_ROWS - 1))) ?
                         '0 : out_row_q + 1'b1;

  // Pair-tracking FSM with registered output channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EVEN;
      first_row_q <= 1'b1;
      shift_q     <= '0;
      row_buf_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
    end else begin
      if (w_accept) begin
        // Tile start is the beat after a closing row, so it stays correct
        // even when the next tile is accepted before the last output drains.
        first_row_q <= bus.in_last;
        if (first_row_q) begin
          shift_q <= shift;
        end
        if (state_q == S_EVEN) begin
          row_buf_q <= w_h;
          if (!bus.in_last) begin
            state_q <= S_ODD;
          end
        end else begin
          state_q <= S_EVEN;
        end
      end

      if (w_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_out_data_d;
        out_last_q  <= w_out_last_d;
      end else if (w_xfer) begin
        out_valid_q <= 1'b0;
      end

      if (w_xfer) begin
        out_row_q <= w_out_row_inc;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_row   = out_row_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_pool_quant.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_pool_quant
// Brief    : Directed bench for npu_pool_quant with a tile-level reference
//            model and a per-cycle output checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_pool_quant;

  localparam int W     = 8;
  localparam int N     = 2;
  localparam int BG    = 6;
  localparam int ACC_W = 2*N+BG+$clog2(25*16);
  localparam int SH_W  = 4;
  localparam int HW    = W/2;
  localparam int RW    = $clog2(W);
  localparam int QMAX  = (1 << N) - 1;
  localparam int AMAX  = (1 << (ACC_W-1)) - 1;

  logic            clk;
  logic            rst_n;
  logic [SH_W-1:0] shift;

  npu_pool_quant_if #(.W(W), .N(N), .BG(BG), .ACC_W(ACC_W)) bus ();

  npu_pool_quant #(.W(W), .N(N), .BG(BG), .ACC_W(ACC_W), .SH_W(SH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (shift),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [HW*N-1:0] data;
    logic            last;
    logic [RW-1:0]   row;
  } exp_t;

  exp_t exp_q[$];

  // Tile-level reference state
  bit  m_first;
  bit  m_have_top;
  int  m_sh;
  int  m_top[HW];
  int  m_row;

  bit              hold_prev;
  logic [HW*N-1:0] hold_data;
  logic            hold_last;
  logic [RW-1:0]   hold_row;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W*ACC_W-1:0] pack_row(input int v0, input int v1, input int v2,
      input int v3, input int v4, input int v5, input int v6, input int v7);
    logic [W*ACC_W-1:0] d;
    int v[W];
    int t;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    v[4] = v4; v[5] = v5; v[6] = v6; v[7] = v7;
    for (int i = 0; i < W; i++) begin
      t = v[i];
      d[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    return d;
  endfunction

  function automatic logic [W*ACC_W-1:0] const_row(input int v);
    return pack_row(v, v, v, v, v, v, v, v);
  endfunction

  function automatic int quant_ref(input longint x, input int sh);
    longint y;
    if (x <= 0) return 0;
    y = x >>> sh;
    return (y > QMAX) ? QMAX : int'(y);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_first    = 1'b1;
    m_have_top = 1'b0;
    m_sh       = 0;
    m_row      = 0;
  endtask

  task automatic model_emit(input int vals[HW], input bit last);
    exp_t e;
    for (int j = 0; j < HW; j++) e.data[j*N +: N] = vals[j][N-1:0];
    e.last = last;
    e.row  = m_row[RW-1:0];
    exp_q.push_back(e);
    m_row = (last || m_row == HW-1) ? 0 : m_row + 1;
  endtask

  task automatic model_accept(input logic [W*ACC_W-1:0] d, input bit last, input int sh);
    int q[W];
    int h[HW];
    int p[HW];
    logic signed [ACC_W-1:0] s;
    if (m_first) m_sh = sh;
    m_first = last;
    for (int i = 0; i < W; i++) begin
      s    = d[i*ACC_W +: ACC_W];
      q[i] = quant_ref(longint'(s), m_sh);
    end
    for (int j = 0; j < HW; j++) h[j] = (q[2*j] > q[2*j+1]) ? q[2*j] : q[2*j+1];
    if (m_have_top) begin
      for (int j = 0; j < HW; j++) p[j] = (m_top[j] > h[j]) ? m_top[j] : h[j];
      model_emit(p, last);
      m_have_top = 1'b0;
    end else if (last) begin
      model_emit(h, 1'b1);
    end else begin
      m_top      = h;
      m_have_top = 1'b1;
    end
  endtask

  // Per-cycle checker: transfers against the model, hold stability, then model update.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      hold_prev = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_xfer: unexpected row data=%0h at %0t", bus.out_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_last !== e.last || bus.out_row !== e.row) begin
            n_fail++;
            $display("FAIL out_xfer: got data=%0h last=%0b row=%0d expected data=%0h last=%0b row=%0d at %0t",
                     bus.out_data, bus.out_last, bus.out_row, e.data, e.last, e.row, $time);
          end
        end
      end
      if (hold_prev) begin
        n_vec++;
        if (!bus.out_valid || bus.out_data !== hold_data ||
            bus.out_last !== hold_last || bus.out_row !== hold_row) begin
          n_fail++;
          $display("FAIL out_hold: got v=%0b data=%0h last=%0b row=%0d expected v=1 data=%0h last=%0b row=%0d at %0t",
                   bus.out_valid, bus.out_data, bus.out_last, bus.out_row,
                   hold_data, hold_last, hold_row, $time);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
      hold_row  = bus.out_row;
      if (bus.in_valid && bus.in_ready) model_accept(bus.in_data, bus.in_last, int'(shift));
    end
  end

  // Present a row until accepted; returns 1 time unit after the accepting edge.
  task automatic send_row(input logic [W*ACC_W-1:0] d, input logic last, input int sh);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    shift        = sh[SH_W-1:0];
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        n_fail++;
        $display("FAIL send_row: in_ready never asserted at %0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pooled rows still missing, expected 0 at %0t", exp_q.size(), $time);
    end
    @(posedge clk);
    #1;
  endtask

  logic [W*ACC_W-1:0] r0, r1;

  initial begin
    n_vec = 0;
    n_fail = 0;
    hold_prev = 1'b0;
    model_reset();
    rst_n         = 1'b0;
    shift         = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data",  bus.out_data, 0);
    chk("reset_out_last",  bus.out_last, 0);
    chk("reset_out_row",   bus.out_row, 0);
    chk("reset_in_ready",  bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pool
    r0 = pack_row(13, 9, -5, 100, 0, 4, 7, 8);
    r1 = pack_row(1, 2, 3, 4, 5, 6, 7, 8);
    send_row(r0, 1'b0, 2);
    chk("basic_no_early_valid", bus.out_valid, 0);
    send_row(r1, 1'b1, 2);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_data",  bus.out_data, 8'h9F);
    chk("basic_last",  bus.out_last, 1);
    chk("basic_row",   bus.out_row, 0);
    drain();

    // Saturation and ReLU
    send_row(const_row(-1), 1'b0, 0);
    send_row(const_row(AMAX), 1'b1, 0);
    chk("sat_data", bus.out_data, 8'hFF);
    send_row(const_row(-7), 1'b0, 0);
    send_row(const_row(-(AMAX+1)), 1'b1, 0);
    chk("relu_data", bus.out_data, 8'h00);
    chk("relu_row",  bus.out_row, 0);
    drain();

    // Backpressure across a 10-row tile (out_row wraps modulo W/2 inside the tile)
    bus.out_ready = 1'b0;
    send_row(pack_row(4, 8, 12, 2, 0, 6, 3, 1), 1'b0, 1);
    send_row(pack_row(1, 1, 9, 9, -4, 2, 5, 7), 1'b0, 1);
    chk("bp_pending", bus.out_valid, 1);
    chk("bp_even_ready", bus.in_ready, 1);
    send_row(pack_row(2, 3, 4, 5, 6, 7, 8, 9), 1'b0, 1);
    chk("bp_odd_blocked", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = pack_row(9, 0, 0, 9, 3, 3, -1, 6);
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_blocked", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 4; k < 10; k++) begin
      send_row(pack_row(k, 2*k, -k, 3*k, k+1, 0, 5, k-3), (k == 9), 1);
    end
    drain();

    // Shift latching: mid-tile change is ignored, next tile picks it up
    send_row(const_row(8), 1'b0, 2);
    send_row(const_row(8), 1'b1, 0);
    chk("shift_held", bus.out_data, 8'hAA);
    send_row(const_row(8), 1'b0, 0);
    send_row(const_row(8), 1'b1, 2);
    chk("shift_next_tile", bus.out_data, 8'hFF);
    drain();

    // Odd-height tile
    send_row(pack_row(1, 2, 3, 0, 0, 0, 1, 1), 1'b0, 0);
    send_row(pack_row(0, 0, 0, 0, 2, 2, 0, 0), 1'b0, 0);
    send_row(pack_row(0, 1, 2, 0, -3, 1, 5, 0), 1'b1, 0);
    chk("odd_data", bus.out_data, 8'hD9);
    chk("odd_last", bus.out_last, 1);
    chk("odd_row",  bus.out_row, 1);
    drain();

    // Asynchronous reset while in the bottom-row state with an output pending
    bus.out_ready = 1'b0;
    send_row(const_row(5), 1'b0, 0);
    send_row(const_row(6), 1'b1, 0);
    send_row(const_row(20), 1'b0, 0);
    chk("pre_reset_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", bus.out_valid, 0);
    chk("async_reset_row",   bus.out_row, 0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_row(r0, 1'b0, 2);
    send_row(r1, 1'b1, 2);
    chk("post_reset_data", bus.out_data, 8'h9F);
    chk("post_reset_row",  bus.out_row, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
